// File: rtl/lcd12864_bus_ctrl_pkg.sv
// Shared types and constants for the LCD12864 (ST7920) parallel bus sequencer.
package lcd12864_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_P_SETUP,
    ST_P_STROBE,
    ST_P_HOLD,
    ST_WAIT
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_AS,
    PH_PW,
    PH_H
  } strb_phase_e;

  localparam int   BF_BIT   = 7;
  localparam logic RS_INSTR = 1'b0;
  localparam logic RS_DATA  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [7:0] CLEAR          = 8'h01;
  localparam logic [7:0] FUNC_SET_BASIC = 8'h30;
  localparam logic [7:0] DISP_ON        = 8'h0C;

  // Bits needed to hold 0..maxv.
  function automatic int cnt_w(input int maxv);
    return (maxv < 1) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/lcd12864_bus_ctrl_if.sv
// Command/response handshake plus LCD pad signals of the bus sequencer.
interface lcd12864_bus_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic       cmd_rw;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       err_timeout;
  logic       lcd_e;
  logic       lcd_rw;
  logic       lcd_rs;
  logic [7:0] lcd_data_o;
  logic       lcd_data_oe;
  logic [7:0] lcd_data_i;

  // Host side: issues commands, sees responses and drives the pad input.
  modport master (
    output cmd_valid, cmd_rs, cmd_rw, cmd_data, lcd_data_i,
    input  cmd_ready, rsp_valid, rsp_data, busy, err_timeout,
    input  lcd_e, lcd_rw, lcd_rs, lcd_data_o, lcd_data_oe
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_rs, cmd_rw, cmd_data, lcd_data_i,
    output cmd_ready, rsp_valid, rsp_data, busy, err_timeout,
    output lcd_e, lcd_rw, lcd_rs, lcd_data_o, lcd_data_oe
  );
endinterface

// File: rtl/lcd12864_strobe.sv
// One E-strobe bus cycle: address setup, E pulse, hold. Restartable on the
// last hold cycle so poll reads can follow each other without an idle gap.
module lcd12864_strobe
  import lcd12864_pkg::*;
#(
  parameter int T_AS = 2,
  parameter int T_PW = 25,
  parameter int T_H  = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic e_o,
  output logic phase_end_o,
  output logic sample_o,
  output logic done_o
);

  localparam int MAXT = (T_AS > T_PW) ? ((T_AS > T_H) ? T_AS : T_H)
                                      : ((T_PW > T_H) ? T_PW : T_H);
  localparam int CW = cnt_w(MAXT);
  localparam logic [CW-1:0] AS_LAST = CW'(T_AS - 1);
  localparam logic [CW-1:0] PW_LAST = CW'(T_PW - 1);
  localparam logic [CW-1:0] H_LAST  = CW'(T_H - 1);

  strb_phase_e   phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  // Phase sequencing and per-phase cycle counting.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q + 1'b1;
    last    = 1'b0;
    case (phase_q)
      PH_AS:   last = (cnt_q == AS_LAST);
      PH_PW:   last = (cnt_q == PW_LAST);
      PH_H:    last = (cnt_q == H_LAST);
      default: cnt_d = '0;
    endcase
    if (last) begin
      cnt_d = '0;
      case (phase_q)
        PH_AS:   phase_d = PH_PW;
        PH_PW:   phase_d = PH_H;
        default: phase_d = PH_IDLE;
      endcase
    end
    if (start_i && ((phase_q == PH_IDLE) || ((phase_q == PH_H) && last))) begin
      phase_d = PH_AS;
      cnt_d   = '0;
    end
  end

  // Phase and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign e_o         = (phase_q == PH_PW);
  assign phase_end_o = last;
  assign sample_o    = last && (phase_q == PH_PW);
  assign done_o      = last && (phase_q == PH_H);

endmodule

// File: rtl/lcd12864_bus_ctrl.sv
// Byte-level LCD12864 bus sequencer: one command per handshake, E timing,
// then either busy-flag polling or a fixed settle wait.
module lcd12864_bus_ctrl
  import lcd12864_pkg::*;
#(
  parameter int T_AS      = 2,
  parameter int T_PW      = 25,
  parameter int T_H       = 2,
  parameter int POLL_BUSY = 0,
  parameter int WAIT_CYC  = 4000,
  parameter int POLL_MAX  = 255
) (
  input logic           csi_clk,
  input logic           csi_reset,
  lcd12864_bus_ctrl_if.slave bus
);

  localparam int WCW = cnt_w(WAIT_CYC);
  localparam int PCW = cnt_w(POLL_MAX);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYC - 1);
  localparam logic [PCW-1:0] POLL_LIM  = PCW'(POLL_MAX);

  state_e         state_q, state_d;
  logic           rs_q, rs_d, rw_q, rw_d, oe_q, oe_d;
  logic [7:0]     data_q, data_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [7:0]     rsp_data_q, rsp_data_d;
  logic           err_q, err_d, bf_q, bf_d;
  logic [PCW-1:0] poll_q, poll_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           strb_start, strb_e, strb_end, strb_sample, strb_done;
  logic           accept;

  lcd12864_strobe #(.T_AS(T_AS), .T_PW(T_PW), .T_H(T_H)) u_strobe (
    .clk_i      (csi_clk),
    .rst_i      (csi_reset),
    .start_i    (strb_start),
    .e_o        (strb_e),
    .phase_end_o(strb_end),
    .sample_o   (strb_sample),
    .done_o     (strb_done)
  );

  assign bus.cmd_ready = (state_q == ST_IDLE) && !csi_reset;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // Next-state and bus-line decisions for the command/poll sequence.
  always_comb begin
    state_d     = state_q;
    rs_d        = rs_q;
    rw_d        = rw_q;
    oe_d        = oe_q;
    data_d      = data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    bf_d        = bf_q;
    poll_d      = poll_q;
    wait_d      = wait_q;
    strb_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rs_d       = bus.cmd_rs;
          rw_d       = bus.cmd_rw;
          data_d     = bus.cmd_data;
          oe_d       = ~bus.cmd_rw;
          poll_d     = '0;
          strb_start = 1'b1;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP:  if (strb_end) state_d = ST_STROBE;
      ST_STROBE: begin
        if (strb_sample) begin
          state_d = ST_HOLD;
          if (rw_q == RW_READ) begin
            rsp_data_d  = bus.lcd_data_i;
            rsp_valid_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (strb_done) begin
          // Hold time has elapsed, so the pad can be released here.
          rw_d = RW_READ;
          oe_d = 1'b0;
          if (POLL_BUSY != 0) begin
            rs_d       = RS_INSTR;
            strb_start = 1'b1;
            state_d    = ST_P_SETUP;
          end else begin
            wait_d  = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_P_SETUP:  if (strb_end) state_d = ST_P_STROBE;
      ST_P_STROBE: begin
        if (strb_sample) begin
          bf_d    = bus.lcd_data_i[BF_BIT];
          state_d = ST_P_HOLD;
        end
      end
      ST_P_HOLD: begin
        if (strb_done) begin
          if (!bf_q) begin
            state_d = ST_IDLE;
          end else if (poll_q < POLL_LIM) begin
            poll_d     = poll_q + 1'b1;
            strb_start = 1'b1;
            state_d    = ST_P_SETUP;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_IDLE;
        else                     wait_d  = wait_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, bus-line and response registers.
  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      state_q     <= ST_IDLE;
      rs_q        <= 1'b0;
      rw_q        <= 1'b1;
      oe_q        <= 1'b0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      bf_q        <= 1'b0;
      poll_q      <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      rs_q        <= rs_d;
      rw_q        <= rw_d;
      oe_q        <= oe_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      bf_q        <= bf_d;
      poll_q      <= poll_d;
      wait_q      <= wait_d;
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.err_timeout = err_q;
  assign bus.lcd_e       = strb_e;
  assign bus.lcd_rw      = rw_q;
  assign bus.lcd_rs      = rs_q;
  assign bus.lcd_data_o  = data_q;
  assign bus.lcd_data_oe = oe_q;

endmodule

// File: tb/tb_lcd12864_bus_ctrl.sv
// Directed bench: dut0 uses fixed-wait mode, dut1 polls BF with POLL_MAX=3.
module tb_lcd12864_bus_ctrl;
  import lcd12864_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  lcd12864_bus_ctrl_if ifc0 ();
  lcd12864_bus_ctrl_if ifc1 ();

  lcd12864_bus_ctrl dut0 (.csi_clk(clk), .csi_reset(rst0), .bus(ifc0.slave));
  lcd12864_bus_ctrl #(.POLL_BUSY(1), .POLL_MAX(3)) dut1 (
    .csi_clk(clk), .csi_reset(rst1), .bus(ifc1.slave));

  int checks = 0;
  int errors = 0;

  logic [7:0] rd_byte0;
  int   rsp_cnt0 = 0, rsp_cnt1 = 0, acc0 = 0;
  int   e1_rises = 0, base1 = 0, busy_polls1 = 0;
  logic e1_prev = 1'b0;

  // LCD models: dut0 returns rd_byte0 while E is high; dut1 reports BF=1
  // for the first busy_polls1 poll strobes after the command strobe.
  assign ifc0.lcd_data_i = ifc0.lcd_e ? rd_byte0 : 8'h00;
  assign ifc1.lcd_data_i = (ifc1.lcd_e && ((e1_rises - base1) <= busy_polls1 + 1)) ? 8'h80 : 8'h00;

  always @(negedge clk) begin
    if (ifc0.rsp_valid) rsp_cnt0 <= rsp_cnt0 + 1;
    if (ifc1.rsp_valid) rsp_cnt1 <= rsp_cnt1 + 1;
    if (ifc1.lcd_e && !e1_prev) e1_rises <= e1_rises + 1;
    e1_prev <= ifc1.lcd_e;
  end

  always @(posedge clk) if (ifc0.cmd_valid && ifc0.cmd_ready) acc0 <= acc0 + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send0(input logic rs, input logic rw, input logic [7:0] d);
    ifc0.cmd_rs = rs; ifc0.cmd_rw = rw; ifc0.cmd_data = d; ifc0.cmd_valid = 1'b1;
    @(negedge clk);
    ifc0.cmd_valid = 1'b0;
  endtask

  task automatic send1(input logic rs, input logic rw, input logic [7:0] d);
    ifc1.cmd_rs = rs; ifc1.cmd_rw = rw; ifc1.cmd_data = d; ifc1.cmd_valid = 1'b1;
    @(negedge clk);
    ifc1.cmd_valid = 1'b0;
  endtask

  // Cycle k=1 is the first cycle after accept; runs until cmd_ready returns.
  task automatic measure0(input logic oe_ref, output int first_e, output int e_cnt,
                          output int ready_k, output int oe_bad, output int oe_on);
    first_e = -1; e_cnt = 0; ready_k = -1; oe_bad = 0; oe_on = 0;
    for (int k = 2; k <= 5000; k++) begin
      @(negedge clk);
      if (ifc0.lcd_data_oe) oe_on++;
      if (ifc0.lcd_e) begin
        if (first_e < 0) first_e = k;
        e_cnt++;
        if (ifc0.lcd_data_oe !== oe_ref) oe_bad++;
      end
      if (ifc0.cmd_ready) begin
        ready_k = k;
        break;
      end
    end
  endtask

  task automatic measure1(output int rises, output int bad, output int ready_k);
    logic prev;
    prev = 1'b0; rises = 0; bad = 0; ready_k = -1;
    for (int k = 2; k <= 2000; k++) begin
      @(negedge clk);
      if (ifc1.lcd_e && !prev) rises++;
      if (ifc1.lcd_e && rises > 1 &&
          (ifc1.lcd_rs !== 1'b0 || ifc1.lcd_rw !== 1'b1 || ifc1.lcd_data_oe !== 1'b0)) bad++;
      prev = ifc1.lcd_e;
      if (ifc1.cmd_ready) begin
        ready_k = k;
        break;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int fe, ec, rk, ob, oon, r0, a0, idx, rises, bad;
    logic [7:0] items [3];
    items = '{CLEAR, DISP_ON, FUNC_SET_BASIC};

    rst0 = 1'b1; rst1 = 1'b1; rd_byte0 = 8'h00;
    ifc0.cmd_valid = 1'b0; ifc0.cmd_rs = 1'b0; ifc0.cmd_rw = 1'b0; ifc0.cmd_data = 8'h00;
    ifc1.cmd_valid = 1'b0; ifc1.cmd_rs = 1'b0; ifc1.cmd_rw = 1'b0; ifc1.cmd_data = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready",   32'(ifc0.cmd_ready), 0);
    chk("rst_e",       32'(ifc0.lcd_e), 0);
    chk("rst_rw",      32'(ifc0.lcd_rw), 1);
    chk("rst_rs",      32'(ifc0.lcd_rs), 0);
    chk("rst_oe",      32'(ifc0.lcd_data_oe), 0);
    chk("rst_data_o",  32'(ifc0.lcd_data_o), 0);
    chk("rst_rsp",     32'({ifc0.rsp_valid, ifc0.rsp_data}), 0);
    chk("rst_busy",    32'(ifc0.busy), 0);
    chk("rst_err",     32'(ifc1.err_timeout), 0);
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    chk("ready_after_rst0", 32'(ifc0.cmd_ready), 1);
    chk("ready_after_rst1", 32'(ifc1.cmd_ready), 1);

    // Instruction write 0x30, fixed wait
    send0(RS_INSTR, RW_WRITE, FUNC_SET_BASIC);
    chk("wr_oe",     32'(ifc0.lcd_data_oe), 1);
    chk("wr_data_o", 32'(ifc0.lcd_data_o), 32'h30);
    chk("wr_rsrw",   32'({ifc0.lcd_rs, ifc0.lcd_rw}), 0);
    chk("wr_busy",   32'(ifc0.busy), 1);
    measure0(1'b1, fe, ec, rk, ob, oon);
    chk("wr_e_first", fe, 3);
    chk("wr_e_len",   ec, 25);
    chk("wr_oe_in_e", ob, 0);
    chk("wr_period",  rk, 4030);
    chk("wr_no_rsp",  rsp_cnt0, 0);
    chk("idle_lines", 32'({ifc0.lcd_e, ifc0.lcd_rw, ifc0.lcd_data_oe}), 32'b010);

    // Data read returning 0xA5
    rd_byte0 = 8'hA5;
    r0 = rsp_cnt0;
    send0(RS_DATA, RW_READ, 8'h5A);
    chk("rd_lines", 32'({ifc0.lcd_rs, ifc0.lcd_rw, ifc0.lcd_data_oe}), 32'b110);
    measure0(1'b0, fe, ec, rk, ob, oon);
    chk("rd_e_len",   ec, 25);
    chk("rd_oe_off",  oon, 0);
    chk("rd_period",  rk, 4030);
    chk("rd_rsp_cnt", rsp_cnt0 - r0, 1);
    chk("rd_rsp_data", 32'(ifc0.rsp_data), 32'hA5);

    // Three writes queued behind a permanently high cmd_valid
    a0 = acc0; idx = 0;
    ifc0.cmd_rs = RS_INSTR; ifc0.cmd_rw = RW_WRITE; ifc0.cmd_data = items[0];
    ifc0.cmd_valid = 1'b1;
    for (int c = 0; c < 13000 && idx < 3; c++) begin
      if (ifc0.cmd_ready) begin
        if (idx > 0) chk("q_held", 32'(ifc0.lcd_data_o), 32'(items[idx-1]));
        @(negedge clk);
        chk("q_data", 32'(ifc0.lcd_data_o), 32'(items[idx]));
        idx++;
        if (idx < 3) ifc0.cmd_data = items[idx];
        else         ifc0.cmd_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    chk("q_done", idx, 3);
    measure0(1'b1, fe, ec, rk, ob, oon);
    chk("q_last_ready", 32'(rk > 0), 1);
    chk("q_accepts",    acc0 - a0, 3);
    chk("rsp_data_held", 32'(ifc0.rsp_data), 32'hA5);

    // Reset pulse while E is high
    send0(RS_INSTR, RW_WRITE, DISP_ON);
    repeat (4) @(negedge clk);
    chk("mid_e_high", 32'(ifc0.lcd_e), 1);
    rst0 = 1'b1;
    @(negedge clk);
    chk("mid_rst_lines", 32'({ifc0.lcd_e, ifc0.lcd_data_oe, ifc0.lcd_rw}), 32'b001);
    chk("mid_rst_ready", 32'(ifc0.cmd_ready), 0);
    chk("mid_rst_busy",  32'(ifc0.busy), 0);
    rst0 = 1'b0;
    #1;
    chk("mid_ready_after", 32'(ifc0.cmd_ready), 1);
    r0 = rsp_cnt0;
    repeat (40) @(negedge clk);
    chk("mid_no_rsp",   rsp_cnt0 - r0, 0);
    chk("mid_e_quiet",  32'(ifc0.lcd_e), 0);
    chk("mid_rsp_data", 32'(ifc0.rsp_data), 0);

    // BF busy for three polls, then clear
    base1 = e1_rises; busy_polls1 = 3; r0 = rsp_cnt1;
    send1(RS_INSTR, RW_WRITE, FUNC_SET_BASIC);
    measure1(rises, bad, rk);
    chk("poll_strobes", rises, 5);
    chk("poll_lines",   bad, 0);
    chk("poll_ready",   rk, 146);
    chk("poll_no_rsp",  rsp_cnt1 - r0, 0);
    chk("poll_no_err",  32'(ifc1.err_timeout), 0);

    // BF stuck high: timeout after four polls
    base1 = e1_rises; busy_polls1 = 1000;
    send1(RS_DATA, RW_WRITE, 8'h41);
    measure1(rises, bad, rk);
    chk("to_strobes", rises, 5);
    chk("to_ready",   rk, 146);
    chk("to_err",     32'(ifc1.err_timeout), 1);

    // Next command still accepted; error flag stays set
    base1 = e1_rises; busy_polls1 = 0;
    send1(RS_INSTR, RW_WRITE, DISP_ON);
    chk("after_to_accept", 32'({ifc1.busy, ifc1.lcd_data_o}), 32'h10C);
    measure1(rises, bad, rk);
    chk("after_to_strobes", rises, 2);
    chk("after_to_ready",   rk, 59);
    chk("err_sticky",       32'(ifc1.err_timeout), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
